// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: op one-hot indices, divider FSM states,
// HI/LO payload type and the operand magnitude helper.
package mdu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    localparam int unsigned MDOP_W     = 8;
    localparam int unsigned MDOP_MULT  = 0;
    localparam int unsigned MDOP_MULTU = 1;
    localparam int unsigned MDOP_DIV   = 2;
    localparam int unsigned MDOP_DIVU  = 3;
    localparam int unsigned MDOP_MFHI  = 4;
    localparam int unsigned MDOP_MFLO  = 5;
    localparam int unsigned MDOP_MTHI  = 6;
    localparam int unsigned MDOP_MTLO  = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider: magnitude latch, one step per cycle, sign fix.
module mdu_div
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    output logic            busy_c,
    output logic            done_c,
    output logic [XLEN-1:0] quo_c,
    output logic [XLEN-1:0] rem_c
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  q_r, d_r, r_r;
    logic             q_neg, r_neg;
    logic [XLEN:0]    r_sh, diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DIV;
            S_DIV:   if (cnt == CNT_W'(DIV_ITER - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A negative 33-bit difference means the divisor did not fit; keep the shifted remainder.
    always_comb begin
        r_sh = {r_r, q_r[XLEN-1]};
        diff = r_sh - {1'b0, d_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            q_r   <= '0;
            d_r   <= '0;
            r_r   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cnt   <= '0;
            q_r   <= mag(opr1, is_signed);
            d_r   <= mag(opr2, is_signed);
            r_r   <= '0;
            q_neg <= is_signed & (opr1[XLEN-1] ^ opr2[XLEN-1]);
            r_neg <= is_signed & opr1[XLEN-1];
        end else if (state == S_DIV) begin
            cnt <= cnt + CNT_W'(1);
            q_r <= {q_r[XLEN-2:0], ~diff[XLEN]};
            r_r <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

    assign busy_c = (state != S_IDLE);
    assign done_c = (state == S_FIX);
    assign quo_c  = q_neg ? XLEN'(-q_r) : q_r;
    assign rem_c  = r_neg ? XLEN'(-r_r) : r_r;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: 2-stage multiplier, iterative divider, HI/LO registers with
// same-cycle completion bypass for mfhi/mflo.
module mdu
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mdu_flush_i,
    input  logic              mdu_stall_i,
    input  logic [XLEN-1:0]   mdu_opr1_i,
    input  logic [XLEN-1:0]   mdu_opr2_i,
    input  logic [MDOP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]   mdu_whi_i,
    input  logic [XLEN-1:0]   mdu_wlo_i,
    output logic              mdu_is_active,
    output logic              mdu_div_active,
    output logic [XLEN-1:0]   mdu_hi_o,
    output logic [XLEN-1:0]   mdu_lo_o
);

    logic              accept, mul_acc, div_req, div_start, mthi_acc, mtlo_acc, mul_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
    logic              mul_v;
    hilo_t             prod, hilo_r, wr, hilo_d;
    logic              div_busy, div_done;
    logic [XLEN-1:0]   div_quo, div_rem;

    assign accept    = (|mdu_op_i) & ~mdu_stall_i & ~mdu_flush_i;
    assign mul_acc   = accept & (mdu_op_i[MDOP_MULT] | mdu_op_i[MDOP_MULTU]);
    assign div_req   = accept & (mdu_op_i[MDOP_DIV] | mdu_op_i[MDOP_DIVU]);
    assign div_start = div_req & ~div_busy;
    assign mthi_acc  = accept & mdu_op_i[MDOP_MTHI];
    assign mtlo_acc  = accept & mdu_op_i[MDOP_MTLO];
    assign mul_sgn   = mdu_op_i[MDOP_MULT];

    // Extending to 64 bits first lets one truncated multiply serve both signednesses.
    always_comb begin
        mul_a    = {{XLEN{mul_sgn & mdu_opr1_i[XLEN-1]}}, mdu_opr1_i};
        mul_b    = {{XLEN{mul_sgn & mdu_opr2_i[XLEN-1]}}, mdu_opr2_i};
        mul_full = mul_a * mul_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_v <= 1'b0;
            prod  <= '0;
        end else begin
            mul_v <= mul_acc;
            if (mul_acc) prod <= mul_full;
        end
    end

    mdu_div u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .is_signed (mdu_op_i[MDOP_DIV]),
        .opr1      (mdu_opr1_i),
        .opr2      (mdu_opr2_i),
        .busy_c    (div_busy),
        .done_c    (div_done),
        .quo_c     (div_quo),
        .rem_c     (div_rem)
    );

    // Completion value is bypassed to the outputs; a younger MTHI/MTLO wins the register.
    always_comb begin
        wr = hilo_r;
        if (mul_v)         wr = prod;
        else if (div_done) wr = '{hi: div_rem, lo: div_quo};
        hilo_d = wr;
        if (mthi_acc) hilo_d.hi = mdu_whi_i;
        if (mtlo_acc) hilo_d.lo = mdu_wlo_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hilo_r <= '0;
        else        hilo_r <= hilo_d;
    end

    assign mdu_hi_o       = wr.hi;
    assign mdu_lo_o       = wr.lo;
    assign mdu_is_active  = mul_v | div_busy;
    assign mdu_div_active = div_busy;

    a_no_div_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(div_req && div_busy));

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes expected HI/LO per mult/div, monitor pops on retire.
module tb_mdu;
    import mdu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush, stall;
    logic [31:0]       opr1, opr2, whi, wlo;
    logic [MDOP_W-1:0] op;
    logic              is_active, div_active;
    logic [31:0]       hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        is_div;
    } exp_t;

    exp_t        scb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mdu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mdu_flush_i    (flush),
        .mdu_stall_i    (stall),
        .mdu_opr1_i     (opr1),
        .mdu_opr2_i     (opr2),
        .mdu_op_i       (op),
        .mdu_whi_i      (whi),
        .mdu_wlo_i      (wlo),
        .mdu_is_active  (is_active),
        .mdu_div_active (div_active),
        .mdu_hi_o       (hi),
        .mdu_lo_o       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint pa, pb;
        pa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        pb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(pa * pb);
    endfunction

    // Returns {remainder, quotient}; divide by zero yields all-ones quotient, remainder = |a|.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ma, mb, q, r;
        ma = (sgn && a[31]) ? 32'(-a) : a;
        mb = (sgn && b[31]) ? 32'(-b) : b;
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = 32'(-q);
        if (sgn && a[31])           r = 32'(-r);
        return {r, q};
    endfunction

    // Drive one accepted op for one cycle; caller sits just after a rising edge.
    task automatic issue(input int unsigned bitn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        op   = MDOP_W'(1 << bitn);
        opr1 = a;
        opr2 = b;
        whi  = a;
        wlo  = b;
        case (bitn)
            MDOP_MULT, MDOP_MULTU: begin
                p = ref_mul(a, b, bitn == MDOP_MULT);
                scb.push_back('{hi: p[63:32], lo: p[31:0], is_div: 1'b0});
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MDOP_DIV, MDOP_DIVU: begin
                p = ref_div(a, b, bitn == MDOP_DIV);
                scb.push_back('{hi: p[63:32], lo: p[31:0], is_div: 1'b1});
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MDOP_MTHI: hi_m = a;
            MDOP_MTLO: lo_m = b;
            default: ;
        endcase
        @(posedge clk);
        #1 op = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!is_active) return;
            n++;
        end
        errors++;
        $display("FAIL wait_idle: timeout, still active after %0d cycles", n);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: a mult retires on every active non-divide cycle; a divide on div_active falling.
    initial begin
        logic prev_div;
        exp_t e;
        prev_div = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_div = 1'b0;
            end else begin
                if ((is_active && !div_active) || (prev_div && !div_active)) begin
                    if (scb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL retire: unexpected result hi=%h lo=%h", hi, lo);
                    end else begin
                        e = scb.pop_front();
                        chk("retire_kind", {31'd0, prev_div}, {31'd0, e.is_div});
                        chk("retire_hi", hi, e.hi);
                        chk("retire_lo", lo, e.lo);
                    end
                end
                prev_div = div_active;
            end
        end
    end

    initial begin
        int n;
        int unsigned ops[6];
        int unsigned sel;
        ops = '{MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU, MDOP_MTHI, MDOP_MTLO};
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; op = '0;
        opr1 = '0; opr2 = '0; whi = '0; wlo = '0;
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_active", {31'd0, is_active}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(MDOP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(n);
        chk("mult_active_cycles", 32'(n), 32'd1);
        @(posedge clk); #1;

        issue(MDOP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        issue(MDOP_MFHI, 32'h0, 32'h0);
        wait_idle(n);
        chk("multu_hi", hi, 32'h0000_0002);
        @(posedge clk); #1;

        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(n);
        chk("div_active_cycles", 32'(n), 32'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        issue(MDOP_DIVU, 32'h1234_5678, 32'h0);
        wait_idle(n);
        chk("divu_zero_cycles", 32'(n), 32'd33);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
        chk("divu_zero_hi", hi, 32'h1234_5678);
        @(posedge clk); #1;

        op = MDOP_W'(1 << MDOP_DIV); opr1 = 32'd100; opr2 = 32'd7; flush = 1'b1;
        @(posedge clk); #1 op = '0; flush = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", {31'd0, div_active}, 32'h0);
        @(posedge clk); #1;
        op = MDOP_W'(1 << MDOP_DIVU); stall = 1'b1;
        @(posedge clk); #1 op = '0; stall = 1'b0;
        @(negedge clk);
        chk("stall_no_accept", {31'd0, div_active}, 32'h0);
        @(posedge clk); #1;

        issue(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1 op = MDOP_W'(1 << MDOP_DIV); flush = 1'b1;
        @(posedge clk); #1 op = '0; flush = 1'b0;
        wait_idle(n);
        chk("flush_mid_div_cycles", 32'(n), 32'd23);
        @(posedge clk); #1;

        issue(MDOP_DIV, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_div_hi", hi, 32'h0);
        chk("rst_mid_div_lo", lo, 32'h0);
        chk("rst_mid_div_active", {31'd0, is_active}, 32'h0);
        chk("rst_mid_div_divact", {31'd0, div_active}, 32'h0);
        scb.delete();
        hi_m = '0; lo_m = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stays_idle", {31'd0, div_active}, 32'h0);
        @(posedge clk); #1;

        issue(MDOP_MULT, 32'h0000_1234, 32'hFFFF_0000);
        issue(MDOP_MTLO, 32'h0, 32'hA5A5_A5A5);
        wait_idle(n);
        chk("mtlo_override_lo", lo, 32'hA5A5_A5A5);
        chk("mtlo_override_hi", hi, hi_m);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) issue(MDOP_MULTU, pick(), pick());
        wait_idle(n);
        chk("b2b_tail_cycles", 32'(n), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            sel = ops[$urandom_range(0, 5)];
            issue(sel, pick(), pick());
            wait_idle(n);
            if (sel == MDOP_DIV || sel == MDOP_DIVU)        chk("rand_div_cycles", 32'(n), 32'd33);
            else if (sel == MDOP_MULT || sel == MDOP_MULTU) chk("rand_mul_cycles", 32'(n), 32'd1);
            chk("rand_hi", hi, hi_m);
            chk("rand_lo", lo, lo_m);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        checks++;
        if (scb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", scb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
